mux_nto1_stream: RTL and testbench

Parametrised N:1 streaming multiplexer, the registered successor to the team's 2:1 gate-level mux. Selects one of CHANNELS valid/ready input streams, either by an explicit select or by round-robin arbitration, and presents it through a single output register stage. It sits between multiple producers and one shared consumer, for example a shared bus or UART transmit path.

---
 rtl/mux_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/mux_nto1_stream.sv | 77 +++++++
 tb/tb_mux_nto1_stream.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and counter width for mux_nto1_stream.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   COUNT_W    = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_grant+1 modulo CHANNELS.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last_grant,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);
  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % CHANNELS]) begin
        grant = SEL_W'((int'(last_grant) + i) % CHANNELS);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N:1 valid/ready mux (fixed select or round-robin) with one output register.
// Optional MUX_STATS_EN adds the out_count transfer counter.
import mux_pkg::*;

module mux_nto1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef MUX_STATS_EN
  output logic [COUNT_W-1:0]        out_count,
`endif
  output logic [SEL_W-1:0]          out_chan
);
  localparam int PAD = 2**SEL_W;
  logic [PAD*WIDTH-1:0] in_pad;
  logic [PAD-1:0]       valid_pad;
  logic [SEL_W-1:0]     rr_grant, grant, last_grant_q, last_grant_d, out_chan_q, out_chan_d;
  logic                 rr_valid, fix_valid, grant_valid, load_en, take;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .req(in_valid), .last_grant(last_grant_q), .grant(rr_grant), .grant_valid(rr_valid)
  );

  // Padding to a power of two keeps an out-of-range sel index inside the vectors.
  always_comb begin
    in_pad = (PAD*WIDTH)'(in);
    valid_pad = PAD'(in_valid);
    fix_valid = (int'(sel) < CHANNELS) && valid_pad[sel];
    grant = (mode == MODE_RR) ? rr_grant : sel;
    grant_valid = (mode == MODE_FIXED) ? fix_valid : rr_valid;
    load_en = !out_valid_q || out_ready;
    take = load_en && grant_valid && !rst;
    in_ready = take ? CHANNELS'(1) << grant : '0;
    out_d = take ? in_pad[grant*WIDTH +: WIDTH] : out_q;
    out_chan_d = take ? grant : out_chan_q;
    last_grant_d = take ? grant : last_grant_q;
    out_valid_d = load_en ? grant_valid : out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_chan_q <= '0;
      out_valid_q <= 1'b0;
      last_grant_q <= SEL_W'(CHANNELS-1);
    end else begin
      out_q <= out_d;
      out_chan_q <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MUX_STATS_EN
  logic [COUNT_W-1:0] count_q, count_d;
  always_comb count_d = count_q + COUNT_W'(out_valid_q && out_ready);
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign out_count = count_q;
`endif

  assign out = out_q;
  assign out_valid = out_valid_q;
  assign out_chan = out_chan_q;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: table-driven check of the 5-channel mux plus backpressure and counter sequences.
module tb_mux_nto1_stream;
  localparam int W = 8;
  localparam int C = 5;
  localparam int S = 3;

  logic clk = 1'b0, rst = 1'b1, mode = 1'b1, out_ready = 1'b1, out_valid;
  logic [S-1:0] sel = '0, out_chan;
  logic [C-1:0] in_valid = '1, in_ready;
  logic [W-1:0] din [C];
  logic [W-1:0] out;
  logic [C*W-1:0] in_bus;
`ifdef MUX_STATS_EN
  logic [15:0] out_count;
`endif
  int total = 0, bad = 0;

  assign in_bus = {din[4], din[3], din[2], din[1], din[0]};
  always #5 clk = ~clk;

  mux_nto1_stream #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .in(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out(out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_STATS_EN
    .out_count(out_count),
`endif
    .out_chan(out_chan)
  );

  typedef struct {
    logic         rst;
    logic         mode;
    logic [S-1:0] sel;
    logic [C-1:0] iv;
    logic         ordy;
    logic [C-1:0] e_rdy;
    logic         e_ov;
    logic [W-1:0] e_out;
    logic [S-1:0] e_chan;
  } vec_t;
  vec_t tv [28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int exp_rx, nxt;
    logic acc_in, acc_out;
    logic [19:0] pat;
    din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'hA5; din[3] = 8'h44; din[4] = 8'h55;
    // reset held two cycles with every channel valid
    tv[0]  = '{1, 1, 0, 5'h1F, 1, 5'h00, 0, 8'h00, 0};
    tv[1]  = '{1, 1, 0, 5'h1F, 1, 5'h00, 0, 8'h00, 0};
    // round-robin over channels 0..3, twice
    tv[2]  = '{0, 1, 0, 5'h0F, 1, 5'h01, 1, 8'h11, 0};
    tv[3]  = '{0, 1, 0, 5'h0F, 1, 5'h02, 1, 8'h22, 1};
    tv[4]  = '{0, 1, 0, 5'h0F, 1, 5'h04, 1, 8'hA5, 2};
    tv[5]  = '{0, 1, 0, 5'h0F, 1, 5'h08, 1, 8'h44, 3};
    tv[6]  = '{0, 1, 0, 5'h0F, 1, 5'h01, 1, 8'h11, 0};
    tv[7]  = '{0, 1, 0, 5'h0F, 1, 5'h02, 1, 8'h22, 1};
    tv[8]  = '{0, 1, 0, 5'h0F, 1, 5'h04, 1, 8'hA5, 2};
    tv[9]  = '{0, 1, 0, 5'h0F, 1, 5'h08, 1, 8'h44, 3};
    // channels 0 and 2 only
    tv[10] = '{0, 1, 0, 5'h05, 1, 5'h01, 1, 8'h11, 0};
    tv[11] = '{0, 1, 0, 5'h05, 1, 5'h04, 1, 8'hA5, 2};
    tv[12] = '{0, 1, 0, 5'h05, 1, 5'h01, 1, 8'h11, 0};
    tv[13] = '{0, 1, 0, 5'h05, 1, 5'h04, 1, 8'hA5, 2};
    // fixed mode, out-of-range sel, highest channel
    tv[14] = '{0, 0, 2, 5'h04, 1, 5'h04, 1, 8'hA5, 2};
    tv[15] = '{0, 0, 5, 5'h1F, 1, 5'h00, 0, 8'hA5, 2};
    tv[16] = '{0, 0, 4, 5'h1F, 1, 5'h10, 1, 8'h55, 4};
    // backpressure for three cycles, then release
    tv[17] = '{0, 1, 0, 5'h1F, 0, 5'h00, 1, 8'h55, 4};
    tv[18] = '{0, 1, 0, 5'h1F, 0, 5'h00, 1, 8'h55, 4};
    tv[19] = '{0, 1, 0, 5'h1F, 0, 5'h00, 1, 8'h55, 4};
    tv[20] = '{0, 1, 0, 5'h1F, 1, 5'h01, 1, 8'h11, 0};
    // mode switch mid-stream, then rr continues from last served channel
    tv[21] = '{0, 1, 0, 5'h1F, 1, 5'h02, 1, 8'h22, 1};
    tv[22] = '{0, 1, 0, 5'h1F, 1, 5'h04, 1, 8'hA5, 2};
    tv[23] = '{0, 0, 1, 5'h1F, 1, 5'h02, 1, 8'h22, 1};
    tv[24] = '{0, 1, 0, 5'h1F, 1, 5'h04, 1, 8'hA5, 2};
    // reset mid-stream, restart at channel 0, then idle
    tv[25] = '{1, 1, 0, 5'h1F, 1, 5'h00, 0, 8'h00, 0};
    tv[26] = '{0, 1, 0, 5'h1F, 1, 5'h01, 1, 8'h11, 0};
    tv[27] = '{0, 1, 0, 5'h00, 1, 5'h00, 0, 8'h11, 0};

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst = tv[i].rst; mode = tv[i].mode; sel = tv[i].sel;
      in_valid = tv[i].iv; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
      chk($sformatf("v%0d out", i), 32'(out), 32'(tv[i].e_out));
      chk($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(tv[i].e_chan));
    end

    // ordered delivery of 6 words from channel 3 under an irregular out_ready pattern
    pat = 20'b1111_1101_1011_0011_0111;
    exp_rx = 1; nxt = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mode = 1'b0; sel = 3'd3; out_ready = pat[c];
      din[3] = W'(nxt); in_valid = (nxt <= 6) ? 5'h08 : 5'h00;
      #1;
      acc_in = in_ready[3];
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        chk("seq word", 32'(out), 32'(exp_rx));
        chk("seq chan", 32'(out_chan), 32'd3);
        exp_rx++;
      end
      @(posedge clk);
      if (acc_in) nxt++;
    end
    chk("seq received", 32'(exp_rx - 1), 32'd6);

`ifdef MUX_STATS_EN
    @(negedge clk);
    rst = 1'b1; mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("count reset", 32'(out_count), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 65536; c++) @(negedge clk);
    chk("count ffff", 32'(out_count), 32'hFFFF);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("count stall", 32'(out_count), 32'hFFFF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("count wrap", 32'(out_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
